// File: rtl/mmips_stack_pkg.sv
// Shared definitions for the stack arbiter: op encodings, FSM states and
// default geometry of the hardware return/data stack.
package mmips_stack_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int DW_DEF    = 8;

    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_TOS  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/stack_rr_grant.sv
// Two-input round-robin grant. The last-granted requester drops to lowest
// priority; requester 0 has priority out of reset.
module stack_rr_grant (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant,
    output logic       o_gid,
    output logic       o_valid
);

    logic r_prio;

    // Pick the priority requester if it asks, otherwise the other one.
    always_comb begin
        o_valid = i_en & (|i_req);
        o_gid   = i_req[r_prio] ? r_prio : ~r_prio;
        o_grant = o_valid ? (2'b01 << o_gid) : 2'b00;
    end

    // Hand priority to the requester that was not just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (o_valid) begin
            r_prio <= ~o_gid;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one hardware stack between the instruction pipeline (port 0) and the
// call/interrupt unit (port 1). One request is in flight at a time.
// Optional feature: define STACK_ARB_GUARD_EN to reject overflow, underflow
// and op 00 with rsp_err instead of forwarding them to the stack.
module stack_arbiter
    import mmips_stack_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [1:0][1:0]              req_op,
    input  logic [1:0][DW-1:0]           req_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_id,
    output logic [DW-1:0]                rsp_data,
    output logic                         rsp_err,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic                         stk_tos,
    output logic [DW-1:0]                stk_push_data,
    input  logic [DW-1:0]                stk_out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int              OW       = $clog2(DEPTH + 1);
    localparam logic [OW-1:0]   OCC_FULL = OW'(DEPTH);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      w_grant;
    logic            w_gid;
    logic            w_gnt_any;
    logic [1:0]      w_op_in;
    logic            w_viol;
    logic [1:0]      r_op;
    logic [OW-1:0]   r_occ;
    logic            r_rsp_valid;
    logic            r_rsp_id;
    logic [DW-1:0]   r_rsp_data;
    logic            r_rsp_err;
    logic            r_stk_push;
    logic            r_stk_pop;
    logic            r_stk_tos;
    logic [DW-1:0]   r_stk_push_data;

    function automatic logic [OW-1:0] occ_inc(input logic [OW-1:0] occ);
        return (occ == OCC_FULL) ? occ : occ + OW'(1);
    endfunction

    function automatic logic [OW-1:0] occ_dec(input logic [OW-1:0] occ);
        return (occ == '0) ? occ : occ - OW'(1);
    endfunction

    stack_rr_grant u_grant (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (r_state == IDLE),
        .i_req   (req_valid),
        .o_grant (w_grant),
        .o_gid   (w_gid),
        .o_valid (w_gnt_any)
    );

    assign req_ready     = w_grant;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_data      = r_rsp_data;
    assign rsp_err       = r_rsp_err;
    assign stk_push      = r_stk_push;
    assign stk_pop       = r_stk_pop;
    assign stk_tos       = r_stk_tos;
    assign stk_push_data = r_stk_push_data;
    assign occupancy     = r_occ;

    // Decode the granted op and run the guard check against current occupancy
    // (stable in IDLE since nothing else touches the stack).
    always_comb begin
        w_op_in = req_op[w_gid];
        w_viol  = 1'b0;
`ifdef STACK_ARB_GUARD_EN
        w_viol = ((w_op_in == OP_PUSH) && (r_occ == OCC_FULL)) ||
                 (((w_op_in == OP_POP) || (w_op_in == OP_TOS)) && (r_occ == '0)) ||
                 (w_op_in == 2'b00);
`else
        if (w_op_in == 2'b00) begin
            w_op_in = OP_TOS;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: PUSH and errors skip the capture cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_any) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = (r_rsp_err || (r_op == OP_PUSH)) ? RESP : CAPT;
            CAPT:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered strobes, response and occupancy. Strobes are set one edge
    // ahead so they are high during ISSUE (push/tos) and CAPT (pop).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op            <= 2'b00;
            r_occ           <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_id        <= 1'b0;
            r_rsp_data      <= '0;
            r_rsp_err       <= 1'b0;
            r_stk_push      <= 1'b0;
            r_stk_pop       <= 1'b0;
            r_stk_tos       <= 1'b0;
            r_stk_push_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        r_op       <= w_op_in;
                        r_rsp_id   <= w_gid;
                        r_rsp_err  <= w_viol;
                        r_rsp_data <= '0;
                        r_stk_push <= (w_op_in == OP_PUSH) && !w_viol;
                        r_stk_tos  <= (w_op_in != OP_PUSH) && !w_viol;
                        if ((w_op_in == OP_PUSH) && !w_viol) begin
                            r_stk_push_data <= req_data[w_gid];
                        end
                    end
                end
                ISSUE: begin
                    r_stk_push <= 1'b0;
                    r_stk_tos  <= 1'b0;
                    if (r_rsp_err || (r_op == OP_PUSH)) begin
                        r_rsp_valid <= 1'b1;
                        if (!r_rsp_err) begin
                            r_occ <= occ_inc(r_occ);
                        end
                    end else begin
                        r_stk_pop <= (r_op == OP_POP);
                    end
                end
                CAPT: begin
                    r_stk_pop   <= 1'b0;
                    r_rsp_data  <= stk_out_data;
                    r_rsp_valid <= 1'b1;
                    if (r_op == OP_POP) begin
                        r_occ <= occ_dec(r_occ);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a response scoreboard and a
// behavioural stack model attached to the strobe interface.
module tb_stack_arbiter;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_TOS  = 2'b11;
`ifdef STACK_ARB_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [1:0]           req_valid = '0;
    logic [1:0]           req_ready;
    logic [1:0][1:0]      req_op = '0;
    logic [1:0][DW-1:0]   req_data = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic                 rsp_id;
    logic [DW-1:0]        rsp_data;
    logic                 rsp_err;
    logic                 stk_push, stk_pop, stk_tos;
    logic [DW-1:0]        stk_push_data;
    logic [DW-1:0]        stk_out_data;
    logic [3:0]           occupancy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cnt_push = 0, cnt_pop = 0, cnt_tos = 0;
    logic [DW-1:0] last_pd = '0;
    rsp_t sb[$];

    logic [DW-1:0] mem [0:DEPTH-1];
    int            sp;

    stack_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_tos(stk_tos),
        .stk_push_data(stk_push_data), .stk_out_data(stk_out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Behavioural stack: tos data is valid the cycle after stk_tos; treated as empty after reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp           <= 0;
            stk_out_data <= '0;
        end else begin
            if (stk_tos) stk_out_data <= (sp > 0) ? mem[sp-1] : '0;
            if (stk_push && sp < DEPTH) begin
                mem[sp] <= stk_push_data;
                sp      <= sp + 1;
            end
            if (stk_pop && sp > 0) sp <= sp - 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare every accepted response with the queue head.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    // Strobe monitor: count pulses and require at most one strobe per cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stk_push) begin cnt_push++; last_pd = stk_push_data; end
                if (stk_tos) cnt_tos++;
                if (stk_pop) cnt_pop++;
                if (stk_push || stk_tos || stk_pop)
                    chk("strobe_onehot", 32'(int'(stk_push) + int'(stk_tos) + int'(stk_pop)), 32'd1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic reset_check();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id_data_err", {23'd0, rsp_id, rsp_data}, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_strobes", {29'd0, stk_push, stk_pop, stk_tos}, 32'd0);
        chk("rst_push_data", 32'(stk_push_data), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        reset_check();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Issue one request and follow it to its response.
    task automatic do_op(input int id, input logic [1:0] op, input logic [DW-1:0] d,
                         input int lat, input int e_push, input int e_tos, input int e_pop,
                         input logic [DW-1:0] e_rdata, input logic e_err, input int e_occ,
                         input int stall);
        int n, k, p0, t0, q0;
        rsp_t e;
        logic [DW-1:0] held;
        e.id = id[0]; e.data = e_rdata; e.err = e_err;
        sb.push_back(e);
        p0 = cnt_push; t0 = cnt_tos; q0 = cnt_pop;
        @(posedge clk); #1;
        if (stall > 0) rsp_ready = 1'b0;
        req_valid[id] = 1'b1; req_op[id] = op; req_data[id] = d;
        k = 0;
        @(negedge clk);
        while (!req_ready[id] && k < 20) begin @(negedge clk); k++; end
        chk("req_ready", 32'(req_ready[id]), 32'd1);
        chk("req_ready_other", 32'(req_ready[1-id]), 32'd0);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        chk("req_ready_one_cycle", 32'(req_ready), 32'd0);
        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("latency", 32'(n), 32'(lat));
        if (stall > 0) begin
            held = rsp_data;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                req_valid[1] = 1'b1; req_op[1] = OP_PUSH; req_data[1] = 8'h77;
                @(negedge clk);
                chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("stall_rsp_data", 32'(rsp_data), 32'(held));
                chk("stall_req_ready", 32'(req_ready), 32'd0);
            end
            @(posedge clk); #1;
            req_valid[1] = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        chk("cnt_push", 32'(cnt_push - p0), 32'(e_push));
        chk("cnt_tos", 32'(cnt_tos - t0), 32'(e_tos));
        chk("cnt_pop", 32'(cnt_pop - q0), 32'(e_pop));
        if (e_push != 0) chk("push_data", 32'(last_pd), 32'(d));
        chk("occupancy", 32'(occupancy), 32'(e_occ));
    endtask

    initial begin
        int gorder[2];
        int g, k;
        rsp_t e;

        // Reset state and first PUSH from requester 0
        #2;
        reset_check();
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(0, OP_PUSH, 8'h5A, 2, 1, 0, 0, 8'h00, 1'b0, 1, 0);

        // Both requesters valid: grants 0 then 1, then a POP returns 0x22
        do_reset();
        e.id = 1'b0; e.data = '0; e.err = 1'b0; sb.push_back(e);
        e.id = 1'b1; sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 2'b11; req_op[0] = OP_PUSH; req_op[1] = OP_PUSH;
        req_data[0] = 8'h11; req_data[1] = 8'h22;
        g = 0; k = 0;
        while (g < 2 && k < 40) begin
            @(negedge clk);
            k++;
            if (req_ready != 2'b00) begin
                gorder[g] = req_ready[1] ? 1 : 0;
                g++;
                @(posedge clk); #1;
                req_valid[gorder[g-1]] = 1'b0;
            end
        end
        chk("grant_count", 32'(g), 32'd2);
        chk("grant_first", 32'(gorder[0]), 32'd0);
        chk("grant_second", 32'(gorder[1]), 32'd1);
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        chk("occ_after_two", 32'(occupancy), 32'd2);
        do_op(0, OP_POP, 8'h00, 3, 0, 1, 1, 8'h22, 1'b0, 1, 0);

        // TOS and op 00 on an empty stack
        do_reset();
        do_op(0, OP_TOS, 8'h00, GUARD ? 2 : 3, 0, GUARD ? 0 : 1, 0, 8'h00, GUARD, 0, 0);
        do_op(1, 2'b00, 8'h00, GUARD ? 2 : 3, 0, GUARD ? 0 : 1, 0, 8'h00, GUARD, 0, 0);

        // Fill to DEPTH, one more PUSH, then drain in LIFO order
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            do_op(0, OP_PUSH, 8'h80 + 8'(i), 2, 1, 0, 0, 8'h00, 1'b0, i + 1, 0);
        do_op(1, OP_PUSH, 8'hFF, 2, GUARD ? 0 : 1, 0, 0, 8'h00, GUARD, DEPTH, 0);
        for (int i = 0; i < DEPTH; i++)
            do_op(i % 2, OP_POP, 8'h00, 3, 0, 1, 1, 8'h87 - 8'(i), 1'b0, DEPTH - 1 - i, 0);

        // Response back-pressure for 5 cycles during a POP
        do_reset();
        do_op(1, OP_PUSH, 8'h66, 2, 1, 0, 0, 8'h00, 1'b0, 1, 0);
        do_op(0, OP_POP, 8'h00, 3, 0, 1, 1, 8'h66, 1'b0, 0, 5);

        // Reset asserted during CAPT of a POP
        do_reset();
        do_op(0, OP_PUSH, 8'h33, 2, 1, 0, 0, 8'h00, 1'b0, 1, 0);
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_op[0] = OP_POP;
        k = 0;
        @(negedge clk);
        while (!req_ready[0] && k < 20) begin @(negedge clk); k++; end
        chk("capt_req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("capt_stk_pop", 32'(stk_pop), 32'd1);
        rst_n = 1'b0;
        #1;
        reset_check();
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(1, OP_PUSH, 8'h44, 2, 1, 0, 0, 8'h00, 1'b0, 1, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
